// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// access-size masks, requester IDs and the alignment check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Bytes never misalign; halves need an even address, words a 4-aligned one.
  function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] off);
    return ((mask == MASK_H) && off[0]) || ((mask == MASK_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte-enable and write-data shift toward
// the addressed lane, read-data shift back to bit 0 and mask to access width.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic [3:0]  mask,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] lane_mask;
  logic [31:0] rdata_shifted;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{mask[gi]}};
  end

  assign be            = mask << off;
  assign wdata_out     = wdata_in << {off, 3'b000};
  assign rdata_shifted = rdata_in >> {off, 3'b000};
  assign rdata_out     = rdata_shifted & lane_mask;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) data-memory arbiter with one transaction in flight.
// Define DMEM_ARB_RR_EN for round-robin on contested requests; otherwise CPU wins.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_sign_mask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mis_err
);

  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              mis_err_q, mis_err_d;
`ifdef DMEM_ARB_RR_EN
  logic              rr_q, rr_d;
`endif

  logic              sel_dbg;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_mask;
  logic [1:0]        sel_off;
  logic [31:0]       sel_wdata;
  logic              sel_we;
  logic              sel_mis;
  logic [3:0]        align_mask;
  logic [1:0]        align_off;
  logic [3:0]        align_be;
  logic [31:0]       align_wdata;
  logic [31:0]       align_rdata;

  // rr_q remembers the last contested winner, so the other side wins next.
`ifdef DMEM_ARB_RR_EN
  assign sel_dbg = dbg_req && (!cpu_req || (rr_q == REQ_CPU));
`else
  assign sel_dbg = dbg_req && !cpu_req;
`endif

  assign sel_addr  = sel_dbg ? dbg_addr : cpu_addr;
  assign sel_mask  = sel_dbg ? MASK_W : cpu_sign_mask;
  assign sel_off   = sel_dbg ? 2'b00 : sel_addr[1:0];
  assign sel_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
  assign sel_we    = sel_dbg ? dbg_we : cpu_we;
  assign sel_mis   = !sel_dbg && is_misaligned(cpu_sign_mask, cpu_addr[1:0]);

  // One aligner serves both phases: incoming request in IDLE, latched access after.
  assign align_mask = (state_q == IDLE) ? sel_mask : mask_q;
  assign align_off  = (state_q == IDLE) ? sel_off : off_q;

  dmem_lane_align u_align (
    .mask      (align_mask),
    .off       (align_off),
    .wdata_in  (sel_wdata),
    .rdata_in  (mem_rdata),
    .be        (align_be),
    .wdata_out (align_wdata),
    .rdata_out (align_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    we_d        = we_q;
    mask_d      = mask_q;
    off_d       = off_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_be_d    = 4'b0000;
    dbg_ack_d   = 1'b0;
    mis_err_d   = 1'b0;
`ifdef DMEM_ARB_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_d = sel_dbg;
          we_d    = sel_we;
          mask_d  = sel_mask;
          off_d   = sel_off;
          cnt_d   = 2'd0;
`ifdef DMEM_ARB_RR_EN
          if (cpu_req && dbg_req) rr_d = sel_dbg;
`endif
          if (sel_mis) begin
            state_d     = DONE;
            mis_err_d   = 1'b1;
            cpu_rdata_d = 32'h0;
          end else begin
            state_d     = ISSUE;
            mem_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = align_wdata;
            mem_be_d    = align_be;
            mem_we_d    = sel_we;
            mem_re_d    = !sel_we;
          end
        end
      end
      ISSUE: begin
        cnt_d = 2'd0;
        if (we_q) begin
          state_d   = DONE;
          dbg_ack_d = (grant_q == REQ_DBG);
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (grant_q == REQ_DBG) begin
            dbg_rdata_d = align_rdata;
            dbg_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = align_rdata;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      grant_q     <= REQ_CPU;
      we_q        <= 1'b0;
      mask_q      <= 4'b0000;
      off_q       <= 2'b00;
      cpu_rdata_q <= 32'h0;
      dbg_rdata_q <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      dbg_ack_q   <= 1'b0;
      mis_err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_q        <= REQ_CPU;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      off_q       <= off_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_be_q    <= mem_be_d;
      dbg_ack_q   <= dbg_ack_d;
      mis_err_q   <= mis_err_d;
`ifdef DMEM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign cpu_stall = cpu_req && !((state_q == DONE) && (grant_q == REQ_CPU));
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mis_err   = mis_err_q;

endmodule
